nxs_work_controller: RTL
========================

Name: nxs_work_controller

Overview:
Sequences the hash core from the 216-byte serial work loader.
- Latches each completed 1728-bit work message and starts the core.
- Aborts and restarts the core when new work arrives mid-job.
- Buffers found nonces.
- Arbitrates the byte-wide UART transmitter between work acknowledgements and nonce reports.

Parameters:
MSG_BITS, 1728, width of a work message (216 bytes)
NONCE_W, 64, width of a nonce; must be a multiple of 8
ACK_BYTE, 8'h57, byte sent to acknowledge accepted work
NONCE_HDR, 8'h4E, header byte preceding each nonce report

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_data  in  MSG_BITS  completed work message from serial loader
rx_done  in  1  one-cycle pulse: rx_data valid this cycle
core_work  out  MSG_BITS  work register; core samples it on core_start
core_start  out  1  one-cycle pulse: begin job
core_abort  out  1  one-cycle pulse: abandon current job
core_busy  in  1  core running; high the cycle after core_start, low when exhausted or aborted
core_found  in  1  one-cycle pulse: core_nonce valid
core_nonce  in  NONCE_W  found nonce
tx_byte  out  8  byte to transmitter
tx_start  out  1  one-cycle pulse: send tx_byte
tx_busy  in  1  transmitter busy
job_active  out  1  high in RUN state
drop_count  out  8  saturating count of dropped nonces

Behaviour:
- Reset values: all outputs 0; core_work 0; both FSMs in IDLE; work_pending, ack_pending and nonce slot cleared. Reset mid-job or mid-report abandons it silently, with no core_abort and no partial bytes resumed.
- Work capture: on rx_done, core_work <= rx_data next cycle, work_pending <= 1, ack_pending <= 1. A repeated rx_done before the ack is sent coalesces into one ack; the newest data wins.
- Core FSM (IDLE, START, RUN, ABORT):
  - IDLE: if work_pending -> START.
  - START: core_start=1 for this one cycle; clear work_pending unless rx_done this cycle; -> RUN.
  - RUN: job_active=1.
    - work_pending -> ABORT (priority).
    - else if !core_busy -> IDLE.
  - ABORT: core_abort=1 for one cycle; -> START.
  - Start latency: rx_done at cycle t gives core_start at t+2 from IDLE, or t+3 from RUN (abort at t+2).
- Nonce capture: core_found is honoured only in RUN and ignored in IDLE/START/ABORT.
  - Found with slot empty: store the nonce.
  - Found with slot full: drop it; drop_count += 1, saturating at 255.
  - Found in the same cycle the TX FSM frees the slot: the new nonce is stored.
- TX FSM (T_IDLE, T_LOAD, T_START, T_GUARD, T_WAIT):
  - T_IDLE arbitration: nonce slot full beats ack_pending.
    - Nonce: copy slot to shift register, free the slot, bytes_left = 1+NONCE_W/8.
    - Ack: clear ack_pending, bytes_left = 1.
  - T_LOAD: present the next byte. Header first, then nonce bytes LSB-first.
  - T_START: wait for !tx_busy, then tx_start=1 one cycle.
  - T_GUARD: one dead cycle.
  - T_WAIT: wait for !tx_busy; decrement bytes_left; if 0 -> T_IDLE, else -> T_LOAD.
  - tx_byte is stable from T_LOAD through T_GUARD.
  - A message is never interleaved. Acks arriving mid-report wait.
- rx_done and core_found in the same cycle: both are processed independently.

Decomposition:
- Shared package nxs_pkg:
  - MSG_BITS, NONCE_W, ACK_BYTE, NONCE_HDR.
  - Core-FSM and TX-FSM state enums.
- One sub-module, nxs_tx_framer: TX FSM, shift register, byte counter. It takes a request/ack for each message type and returns slot-free.
- The core FSM, work register, nonce slot and drop counter remain in the top.

Test Plan:
- Reset, then rx_done with rx_data=pattern A; core_busy high 1 cycle after start:
  - core_work=A at t+1; core_start at t+2; job_active from t+3.
  - Exactly one tx_start, carrying 8'h57.
- Core running, second rx_done with pattern B:
  - core_abort at t+2, core_start at t+3, core_work=B.
  - Exactly one additional 8'h57 ack.
- core_found with nonce 64'h0123456789ABCDEF in RUN:
  - 9 tx_start pulses with bytes 4E, EF, CD, AB, 89, 67, 45, 23, 01.
  - No tx_start while tx_busy=1.
- Three core_found pulses while the first report is transmitting:
  - First and second reported in order; third dropped; drop_count=1.
  - Repeat 300 drops: drop_count saturates at 255.
- rx_done and core_found in the same cycle, with an ack and a nonce both pending at T_IDLE:
  - Nonce report (9 bytes) sent first, then 8'h57.
  - core_found in IDLE is ignored.
- rst asserted mid-report (after 4 bytes) and during ABORT:
  - Next cycle all outputs 0, no further tx_start, no core_start.
  - drop_count=0.

Source files
------------

// File: rtl/nxs_pkg.sv
// Shared constants and state encodings for the work controller and its TX framer.
package nxs_pkg;

  localparam int MSG_BITS          = 1728;
  localparam int NONCE_W           = 64;
  localparam logic [7:0] ACK_BYTE  = 8'h57;
  localparam logic [7:0] NONCE_HDR = 8'h4E;
  localparam int NONCE_BYTES       = NONCE_W / 8;
  localparam int CNT_W             = $clog2(NONCE_BYTES + 2);

  typedef enum logic [1:0] {
    C_IDLE,
    C_START,
    C_RUN,
    C_ABORT
  } core_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_LOAD,
    T_START,
    T_GUARD,
    T_WAIT
  } tx_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/nxs_if.sv
// Hash-core and UART-transmitter signals as seen by the controller (master) and the far side (slave).
interface nxs_if;
  import nxs_pkg::*;

  logic [MSG_BITS-1:0] core_work;
  logic                core_start;
  logic                core_abort;
  logic                core_busy;
  logic                core_found;
  logic [NONCE_W-1:0]  core_nonce;
  logic [7:0]          tx_byte;
  logic                tx_start;
  logic                tx_busy;

  modport master (
    output core_work, core_start, core_abort, tx_byte, tx_start,
    input  core_busy, core_found, core_nonce, tx_busy
  );

  modport slave (
    input  core_work, core_start, core_abort, tx_byte, tx_start,
    output core_busy, core_found, core_nonce, tx_busy
  );

endinterface

// File: rtl/nxs_tx_framer.sv
// Serialises one message at a time to the byte transmitter: either a single ack byte
// or a header byte followed by the nonce LSB-first.
module nxs_tx_framer
  import nxs_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               nonce_req,
  input  logic [NONCE_W-1:0] nonce_data,
  output logic               nonce_take,
  input  logic               ack_req,
  output logic               ack_take,
  output logic [7:0]         tx_byte,
  output logic               tx_start,
  input  logic               tx_busy
);

  tx_state_t          state;
  logic [NONCE_W-1:0] shreg;
  logic [CNT_W-1:0]   bytes_left;
  logic               hdr_next;
  logic               is_nonce;

  // Arbitration happens only between messages, so a report is never interleaved with an ack.
  assign nonce_take = (state == T_IDLE) && nonce_req;
  assign ack_take   = (state == T_IDLE) && !nonce_req && ack_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= T_IDLE;
      shreg      <= '0;
      bytes_left <= '0;
      hdr_next   <= 1'b0;
      is_nonce   <= 1'b0;
      tx_byte    <= 8'd0;
      tx_start   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        T_IDLE: begin
          if (nonce_req) begin
            shreg      <= nonce_data;
            bytes_left <= CNT_W'(NONCE_BYTES + 1);
            is_nonce   <= 1'b1;
            hdr_next   <= 1'b1;
            state      <= T_LOAD;
          end else if (ack_req) begin
            bytes_left <= CNT_W'(1);
            is_nonce   <= 1'b0;
            hdr_next   <= 1'b1;
            state      <= T_LOAD;
          end
        end
        T_LOAD: begin
          if (hdr_next) begin
            tx_byte  <= is_nonce ? NONCE_HDR : ACK_BYTE;
            hdr_next <= 1'b0;
          end else begin
            tx_byte <= shreg[7:0];
            shreg   <= shreg >> 8;
          end
          state <= T_START;
        end
        T_START: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= T_GUARD;
          end
        end
        // The guard cycle gives the transmitter time to raise busy before it is polled.
        T_GUARD: state <= T_WAIT;
        T_WAIT: begin
          if (!tx_busy) begin
            bytes_left <= bytes_left - CNT_W'(1);
            state      <= (bytes_left == CNT_W'(1)) ? T_IDLE : T_LOAD;
          end
        end
        default: state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/nxs_work_controller.sv
// Latches work from the serial loader, starts/aborts the hash core, buffers one found
// nonce and hands acks and nonce reports to the TX framer.
module nxs_work_controller
  import nxs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [MSG_BITS-1:0] rx_data,
  input  logic                rx_done,
  nxs_if.master               bus,
  output logic                job_active,
  output logic [7:0]          drop_count
);

  core_state_t        state;
  logic               work_pending;
  logic               ack_pending;
  logic               slot_full;
  logic [NONCE_W-1:0] slot;
  logic               nonce_take;
  logic               ack_take;
  logic               found_ok;
  logic [7:0]         tx_byte;
  logic               tx_start;

  assign found_ok     = bus.core_found && (state == C_RUN);
  assign bus.tx_byte  = tx_byte;
  assign bus.tx_start = tx_start;

  // A fresh rx_done wins over clearing, so back-to-back work coalesces into one pending ack/start.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.core_work <= '0;
      work_pending  <= 1'b0;
      ack_pending   <= 1'b0;
    end else if (rx_done) begin
      bus.core_work <= rx_data;
      work_pending  <= 1'b1;
      ack_pending   <= 1'b1;
    end else begin
      if (state == C_START) work_pending <= 1'b0;
      if (ack_take)         ack_pending  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= C_IDLE;
      bus.core_start <= 1'b0;
      bus.core_abort <= 1'b0;
      job_active     <= 1'b0;
    end else begin
      bus.core_start <= 1'b0;
      bus.core_abort <= 1'b0;
      case (state)
        C_IDLE: begin
          if (work_pending) begin
            state          <= C_START;
            bus.core_start <= 1'b1;
          end
        end
        C_START: begin
          state      <= C_RUN;
          job_active <= 1'b1;
        end
        C_RUN: begin
          if (work_pending) begin
            state          <= C_ABORT;
            bus.core_abort <= 1'b1;
            job_active     <= 1'b0;
          end else if (!bus.core_busy) begin
            state      <= C_IDLE;
            job_active <= 1'b0;
          end
        end
        C_ABORT: begin
          state          <= C_START;
          bus.core_start <= 1'b1;
        end
        default: state <= C_IDLE;
      endcase
    end
  end

  // The framer copies the old slot in the same cycle it is refilled, so a found nonce then is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full  <= 1'b0;
      slot       <= '0;
      drop_count <= 8'd0;
    end else if (found_ok) begin
      if (!slot_full || nonce_take) begin
        slot      <= bus.core_nonce;
        slot_full <= 1'b1;
      end else begin
        drop_count <= sat_inc8(drop_count);
      end
    end else if (nonce_take) begin
      slot_full <= 1'b0;
    end
  end

  nxs_tx_framer u_framer (
    .clk        (clk),
    .rst        (rst),
    .nonce_req  (slot_full),
    .nonce_data (slot),
    .nonce_take (nonce_take),
    .ack_req    (ack_pending),
    .ack_take   (ack_take),
    .tx_byte    (tx_byte),
    .tx_start   (tx_start),
    .tx_busy    (bus.tx_busy)
  );

endmodule
